// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg : shared state encoding and vector constants for irq_ctrl.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [31:0] c_VEC_BASE_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] c_VEC_STRIDE       = 32'd4;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc : lowest-index-wins priority encoder.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_vec,
  output logic [IDW-1:0] o_id,
  output logic           o_valid
);

  always_comb begin
    o_id    = '0;
    o_valid = |i_vec;
    // Scanning downwards lets the lowest set index overwrite the others.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_id = IDW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl : edge-triggered, fixed-priority, non-nesting interrupt controller.
// Optional IRQ_MISS_CNT_EN adds per-source saturating missed-edge counters.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_SRC    = 4,
  parameter logic [31:0] VEC_BASE = c_VEC_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_i,
  input  logic                     en_we,
  input  logic [N_SRC-1:0]         en_wdata,
  input  logic [31:0]              ret_pc,
  input  logic                     irq_ack,
  input  logic                     mret,
  output logic                     irq_req,
  output logic [31:0]              irq_vec,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  output logic [31:0]              epc,
  output logic [N_SRC-1:0]         pending_o,
  output logic                     in_service
`ifdef IRQ_MISS_CNT_EN
  ,
  output logic [8*N_SRC-1:0]       miss_cnt
`endif
);

  localparam int IDW = $clog2(N_SRC);

  irq_state_e       r_state;
  irq_state_e       w_state_nxt;
  logic [N_SRC-1:0] r_src_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [IDW-1:0]   r_irq_id;
  logic [31:0]      r_epc;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_clr;
  logic [IDW-1:0]   w_enc_id;
  logic             w_enc_valid;
  logic             w_take_ack;

  assign w_edge     = src_i & ~r_src_prev;
  assign w_active   = r_pending & r_enable;
  assign w_take_ack = (r_state == REQ) && irq_ack;
  assign w_clr      = w_take_ack ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_irq_id) : '0;

  irq_prio_enc #(
    .N   (N_SRC),
    .IDW (IDW)
  ) u_prio_enc (
    .i_vec   (w_active),
    .o_id    (w_enc_id),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_enc_valid) w_state_nxt = REQ;
      REQ:     if (irq_ack)     w_state_nxt = SERVICE;
      SERVICE: if (mret)        w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    // Sampling src_i during reset hides sources that are already high.
    r_src_prev <= src_i;
    if (reset) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_irq_id  <= '0;
      r_epc     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (en_we)                          r_enable <= en_wdata;
      if (r_state == IDLE && w_enc_valid) r_irq_id <= w_enc_id;
      if (w_take_ack)                     r_epc    <= ret_pc;
    end
  end

  assign irq_req    = (r_state == REQ);
  assign in_service = (r_state == SERVICE);
  assign irq_id     = r_irq_id;
  assign irq_vec    = VEC_BASE + c_VEC_STRIDE * 32'(r_irq_id);
  assign epc        = r_epc;
  assign pending_o  = r_pending;

`ifdef IRQ_MISS_CNT_EN
  for (genvar g = 0; g < N_SRC; g++) begin : g_miss
    logic [7:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_edge[g] && r_pending[g] && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
    assign miss_cnt[8*g +: 8] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl : directed and random checks of irq_ctrl against a behavioural model.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_i;
  logic        en_we;
  logic [3:0]  en_wdata;
  logic [31:0] ret_pc;
  logic        irq_ack;
  logic        mret;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic [1:0]  irq_id;
  logic [31:0] epc;
  logic [3:0]  pending_o;
  logic        in_service;
`ifdef IRQ_MISS_CNT_EN
  logic [31:0] miss_cnt;
`endif

  irq_ctrl #(.N_SRC(4), .VEC_BASE(32'h0000_0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_i      (src_i),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .ret_pc     (ret_pc),
    .irq_ack    (irq_ack),
    .mret       (mret),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .irq_id     (irq_id),
    .epc        (epc),
    .pending_o  (pending_o),
    .in_service (in_service)
`ifdef IRQ_MISS_CNT_EN
    ,
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: pending/enable sets, a "waiting" and "busy" flag.
  bit [3:0]    m_pend, m_en, m_prev;
  int          m_id;
  bit          m_req, m_svc;
  logic [31:0] m_epc;
  int          m_miss [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit [3:0] s, input bit we, input bit [3:0] wd,
                            input logic [31:0] pc, input bit ak, input bit mr, input bit rs);
    bit [3:0] ev;
    bit [3:0] clr;
    if (rs) begin
      m_pend = 0; m_en = 0; m_epc = 0; m_req = 0; m_svc = 0; m_id = 0; m_prev = s;
      for (int i = 0; i < 4; i++) m_miss[i] = 0;
    end else begin
      ev  = s & ~m_prev;
      clr = 0;
      for (int i = 0; i < 4; i++)
        if (ev[i] && m_pend[i] && m_miss[i] < 255) m_miss[i]++;
      if (!m_req && !m_svc) begin
        if ((m_pend & m_en) != 0) begin
          m_req = 1;
          for (int i = 3; i >= 0; i--) if (m_pend[i] && m_en[i]) m_id = i;
        end
      end else if (m_req) begin
        if (ak) begin
          clr[m_id] = 1'b1; m_req = 0; m_svc = 1; m_epc = pc;
        end
      end else if (mr) begin
        m_svc = 0;
      end
      m_pend = (m_pend & ~clr) | ev;
      m_prev = s;
      if (we) m_en = wd;
    end
  endtask

  task automatic check_all();
    chk("irq_req",    {31'd0, irq_req},    {31'd0, m_req});
    chk("in_service", {31'd0, in_service}, {31'd0, m_svc});
    chk("irq_id",     {30'd0, irq_id},     32'(m_id));
    chk("irq_vec",    irq_vec,             32'h100 + 32'(4 * m_id));
    chk("epc",        epc,                 m_epc);
    chk("pending_o",  {28'd0, pending_o},  {28'd0, m_pend});
`ifdef IRQ_MISS_CNT_EN
    for (int i = 0; i < 4; i++) chk("miss_cnt", {24'd0, miss_cnt[8*i +: 8]}, 32'(m_miss[i]));
`endif
  endtask

  task automatic tick(input bit [3:0] s, input bit we, input bit [3:0] wd,
                      input logic [31:0] pc, input bit ak, input bit mr, input bit rs);
    src_i = s; en_we = we; en_wdata = wd; ret_pc = pc;
    irq_ack = ak; mret = mr; reset = rs;
    @(posedge clk);
    #1;
    model_step(s, we, wd, pc, ak, mr, rs);
    check_all();
  endtask

  task automatic t_src(input bit [3:0] s);                 tick(s, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_wen(input bit [3:0] wd);                tick(0, 1, wd, 0, 0, 0, 0); endtask
  task automatic t_ack(input logic [31:0] pc, input bit [3:0] s); tick(s, 0, 0, pc, 1, 0, 0); endtask
  task automatic t_mret();                                 tick(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic t_rst(input bit [3:0] s);                 tick(s, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    // Reset state
    t_rst(4'b0000);
    chk("rst_req", {31'd0, irq_req}, 32'd0);
    chk("rst_vec", irq_vec, 32'h100);

    // Single source, latency and acknowledge
    t_wen(4'b0001);
    t_src(4'b0001);
    chk("lat_pend", {28'd0, pending_o}, 32'h1);
    chk("lat_req1", {31'd0, irq_req}, 32'd0);
    t_src(4'b0000);
    chk("lat_req2", {31'd0, irq_req}, 32'd1);
    chk("lat_vec",  irq_vec, 32'h100);
    t_ack(32'h40, 4'b0000);
    chk("ack_epc", epc, 32'h40);
    chk("ack_svc", {31'd0, in_service}, 32'd1);
    chk("ack_req", {31'd0, irq_req}, 32'd0);
    t_mret();

    // Fixed priority between simultaneous sources
    t_rst(4'b0000);
    t_wen(4'b1111);
    t_src(4'b1010);
    t_src(4'b0000);
    chk("pri_id1",  {30'd0, irq_id}, 32'd1);
    chk("pri_vec1", irq_vec, 32'h104);
    t_ack(32'h80, 4'b0000);
    t_mret();
    t_src(4'b0000);
    chk("pri_id3",  {30'd0, irq_id}, 32'd3);
    chk("pri_vec3", irq_vec, 32'h10C);
    t_ack(32'h84, 4'b0000);
    t_mret();

    // Masked pending, later enabled
    t_rst(4'b0000);
    t_src(4'b0100);
    t_src(4'b0000);
    chk("msk_pend", {28'd0, pending_o}, 32'h4);
    chk("msk_req",  {31'd0, irq_req}, 32'd0);
    t_wen(4'b0100);
    chk("msk_req0", {31'd0, irq_req}, 32'd0);
    t_src(4'b0000);
    chk("msk_req1", {31'd0, irq_req}, 32'd1);
    chk("msk_vec",  irq_vec, 32'h108);
    t_ack(32'h0, 4'b0000);
    t_mret();

    // New edge coinciding with its own clear
    t_rst(4'b0000);
    t_wen(4'b0001);
    t_src(4'b0001);
    t_src(4'b0000);
    t_ack(32'h1234, 4'b0001);
    chk("coin_pend", {28'd0, pending_o}, 32'h1);
    chk("coin_svc",  {31'd0, in_service}, 32'd1);
    t_src(4'b0000);
    chk("coin_nest", {31'd0, irq_req}, 32'd0);
    t_mret();
    t_src(4'b0000);
    chk("coin_req", {31'd0, irq_req}, 32'd1);
    t_ack(32'h0, 4'b0000);

    // Reset during SERVICE with all sources high
    t_rst(4'b1111);
    chk("rsv_svc",  {31'd0, in_service}, 32'd0);
    chk("rsv_req",  {31'd0, irq_req}, 32'd0);
    chk("rsv_epc",  epc, 32'h0);
    chk("rsv_vec",  irq_vec, 32'h100);
    chk("rsv_pend", {28'd0, pending_o}, 32'h0);
    t_src(4'b1111);
    t_src(4'b1111);
    chk("rsv_held", {28'd0, pending_o}, 32'h0);

`ifdef IRQ_MISS_CNT_EN
    // Saturating missed-edge count while masked
    t_rst(4'b0000);
    t_src(4'b0001);
    for (int k = 0; k < 300; k++) begin
      t_src(4'b0000);
      t_src(4'b0001);
    end
    chk("miss_sat", {24'd0, miss_cnt[7:0]}, 32'd255);
`endif

    // Random traffic against the model
    t_rst(4'b0000);
    for (int k = 0; k < 600; k++) begin
      tick(4'($urandom), ($urandom % 8) == 0, 4'($urandom), $urandom,
           ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 80) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
